// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and load/store with starvation guard, flush drop and timeout.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIM = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  input  logic                flush,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_err
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
  state_t state;
  logic [3:0] starve_cnt;
  logic [7:0] wait_cnt;
  logic drop, busy, timeout, done;
  assign busy = state != IDLE;
  // wait_cnt is 0 on the first busy cycle, so the abort lands on busy cycle MAX_WAIT
  assign timeout = busy && !mem_ack && wait_cnt == 8'(MAX_WAIT - 1);
  assign done = busy && (mem_ack || timeout);
  assign if_gnt = rst_n && state == IDLE && if_req && !flush && (!d_req || starve_cnt == 4'(STARVE_LIM));
  assign d_gnt = rst_n && state == IDLE && d_req && !if_gnt;
  assign if_rvalid = state == BUSY_IF && done && !drop && !flush;
  assign d_rvalid = state == BUSY_D && done;
  assign if_rdata = if_rvalid && mem_ack ? mem_rdata : '0;
  assign d_rdata = d_rvalid && mem_ack ? mem_rdata : '0;
  assign bus_err = timeout;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      starve_cnt <= '0;
      wait_cnt <= '0;
      drop <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
    end else begin
      if (if_gnt)
        starve_cnt <= '0;
      else if (if_req && d_gnt && starve_cnt != 4'(STARVE_LIM))
        starve_cnt <= starve_cnt + 4'd1;
      if (if_gnt || d_gnt) begin
        state <= if_gnt ? BUSY_IF : BUSY_D;
        mem_req <= 1'b1;
        mem_we <= d_gnt && d_we;
        mem_addr <= if_gnt ? if_addr : d_addr;
        mem_wdata <= if_gnt ? '0 : d_wdata;
        mem_be <= if_gnt ? '1 : d_be;
        wait_cnt <= '0;
        drop <= 1'b0;
      end else if (done) begin
        state <= IDLE;
        mem_req <= 1'b0;
        mem_we <= 1'b0;
        drop <= 1'b0;
      end else if (busy) begin
        wait_cnt <= wait_cnt + 8'd1;
        drop <= drop || (state == BUSY_IF && flush);
      end
    end
  end
endmodule
